// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// default operand width and iteration-counter width.
package seq_divider_pkg;

  localparam int DEFAULT_DATA_LEN = 32;
  localparam int CNT_W            = $clog2(DEFAULT_DATA_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_adder.sv
// Shared ripple adder used by the execute stage: Sum = A + B + Cin with
// carry-out, zero and signed-overflow flags.
module Adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Zero,
  output logic             Overflow
);

  logic [WIDTH:0] full;

  // Full-width add so the carry-out falls out as the top bit.
  always_comb begin
    full     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    Sum      = full[WIDTH-1:0];
    Carry    = full[WIDTH];
    Zero     = (full[WIDTH-1:0] == '0);
    Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (full[WIDTH-1] != A[WIDTH-1]);
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle through a shared
// Adder. Define SEQ_DIVIDER_SIGNED_EN to honour is_signed (abs/negate logic);
// without it every request is treated as unsigned and FIX is a pass-through.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DATA_LEN = DEFAULT_DATA_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_signed,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder,
  output logic                div_zero
);

  localparam int CW = $clog2(DATA_LEN);

  state_t              state, state_next;
  logic [DATA_LEN-1:0] q_reg, rem_reg, dvsr_reg;
  logic [CW-1:0]       cnt;
  logic                dz_reg;
  logic                accept, last_iter;
  logic [DATA_LEN-1:0] dvd_mag, dvs_mag;
  logic [DATA_LEN:0]   trial;
  logic                no_borrow, adder_zero, adder_ovf;
  logic [2:0]          unused_adder;

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (cnt == CW'(DATA_LEN - 1));

  // Trial subtraction {rem, q_msb} - {0, divisor} as A + ~B + 1; carry set
  // means no borrow, i.e. the divisor fits and the quotient bit is 1.
  Adder #(.WIDTH(DATA_LEN + 1)) u_adder (
    .A        ({rem_reg, q_reg[DATA_LEN-1]}),
    .B        (~{1'b0, dvsr_reg}),
    .Cin      (1'b1),
    .Sum      (trial),
    .Carry    (no_borrow),
    .Zero     (adder_zero),
    .Overflow (adder_ovf)
  );

  // The trial MSB is always zero when it is kept, so only the low bits matter.
  assign unused_adder = {trial[DATA_LEN], adder_zero, adder_ovf};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic dvd_neg, dvs_neg, neg_q, neg_r;
  assign dvd_neg = is_signed & dividend[DATA_LEN-1];
  assign dvs_neg = is_signed & divisor[DATA_LEN-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;
`else
  logic unused_signed;
  assign unused_signed = is_signed;
  assign dvd_mag       = dividend;
  assign dvs_mag       = divisor;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (divisor == '0) ? DONE : BUSY;
      end
      BUSY: if (last_iter) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract iterations and sign fix-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= '0;
      rem_reg  <= '0;
      dvsr_reg <= '0;
      cnt      <= '0;
      dz_reg   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          cnt      <= '0;
          dvsr_reg <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_q    <= dvd_neg ^ dvs_neg;
          neg_r    <= dvd_neg;
`endif
          if (divisor == '0) begin
            q_reg   <= '1;
            rem_reg <= dividend;
            dz_reg  <= 1'b1;
          end else begin
            q_reg   <= dvd_mag;
            rem_reg <= '0;
            dz_reg  <= 1'b0;
          end
        end
        BUSY: begin
          rem_reg <= no_borrow ? trial[DATA_LEN-1:0]
                               : {rem_reg[DATA_LEN-2:0], q_reg[DATA_LEN-1]};
          q_reg   <= {q_reg[DATA_LEN-2:0], no_borrow};
          cnt     <= cnt + 1'b1;
        end
        FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          if (neg_q) q_reg   <= -q_reg;
          if (neg_r) rem_reg <= -rem_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  assign quotient  = q_reg;
  assign remainder = rem_reg;
  assign div_zero  = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: reset state, a directed vector table,
// backpressure and mid-operation reset sequences, then random requests
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int W = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk, rst;
  logic         in_valid, in_ready, is_signed;
  logic [W-1:0] dividend, divisor;
  logic         out_valid, out_ready;
  logic [W-1:0] quotient, remainder;
  logic         div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.DATA_LEN(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with RISC-V divide-by-zero rules.
  function automatic vec_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t   v;
    longint sa, sb, qq, rr;
    v.sgn = sgn; v.a = a; v.b = b;
    if (b == 0) begin
      v.q = '1; v.r = a; v.dz = 1'b1;
    end else if (sgn && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      v.q = qq[W-1:0]; v.r = rr[W-1:0]; v.dz = 1'b0;
    end else begin
      v.q = a / b; v.r = a % b; v.dz = 1'b0;
    end
    return v;
  endfunction

  // Issue one request from a negedge, wait for the result, consume it.
  // lat counts rising edges from the request cycle to out_valid.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    check("ready_before_req", {31'd0, in_ready}, 32'd1);
    is_signed = sgn; dividend = a; divisor = b; in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
    q = quotient; r = remainder; dz = div_zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after_consume", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic apply(input string name, input vec_t v);
    logic [W-1:0] q, r;
    logic         dz;
    int           lat;
    run_div(v.sgn, v.a, v.b, q, r, dz, lat);
    check({name, "_q"}, q, v.q);
    check({name, "_r"}, r, v.r);
    check({name, "_dz"}, {31'd0, dz}, {31'd0, v.dz});
    check({name, "_lat"}, lat, v.dz ? 32'd1 : 32'd34);
  endtask

  vec_t tbl[9];

  initial begin
    logic [W-1:0] q, r, sq, sr;
    logic         dz;
    int           lat, guard;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient",  quotient,  32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero",  {31'd0, div_zero},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors; signed rows depend on whether signed support is built.
    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[2] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[3] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[6] = '{1'b0, 32'd7,          32'd9,          32'd0,          32'd7,          1'b0};
`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[8] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0};
`else
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    tbl[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd0,          32'd7,          1'b0};
    tbl[8] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd0,          32'hFFFF_FFF8,  1'b0};
`endif
    for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Backpressure: result held 5 cycles while a competing request is offered.
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    guard = 0;
    do begin @(negedge clk); in_valid = 1'b0; guard++; end
    while (!out_valid && guard < 200);
    sq = quotient; sr = remainder;
    check("bp_q", sq, 32'd333);
    check("bp_r", sr, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; dividend = 32'd77; divisor = 32'd5;
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready},  32'd0);
      check("bp_hold_q", quotient,  32'd333);
      check("bp_hold_r", remainder, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check("bp_after_ready", {31'd0, in_ready},  32'd1);
    @(negedge clk);
    check("bp_not_accepted", {31'd0, in_ready}, 32'd1);

    // Reset during iteration 10 discards the in-flight divide.
    dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
    check("mid_rst_q",      quotient,  32'd0);
    run_div(1'b0, 32'd9, 32'd3, q, r, dz, lat);
    check("post_rst_q", q, 32'd3);
    check("post_rst_r", r, 32'd0);
    check("post_rst_lat", lat, 32'd34);

    // Random requests against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] a, b;
      logic         sgn;
      int           sel;
      vec_t         v;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        3:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      v = model(sgn, a, b);
      apply("rand", v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
